// File: rtl/match_rec_pkg.sv
// Shared types and widths for the received-match collector.
// Imported by the interface, the page RAM and the collector top.
package match_rec_pkg;

   localparam int MATCH_W = 44;
   localparam int TAG_HI  = 43;
   localparam int TAG_LO  = 40;
   localparam int BX_W    = 3;

   typedef logic [MATCH_W-1:0] match_t;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

endpackage

// File: rtl/match_rec_collector_if.sv
// Match stream in, closed-page read/status out.
// MATCH_REC_STATS_EN adds the drop_cnt status word.
interface match_rec_collector_if #(
   parameter int ADDR_W = 6
);
   import match_rec_pkg::*;

   logic              start;
   logic              valid;
   match_t            match;
   logic [ADDR_W-1:0] rd_add;
   match_t            matchout;
   logic [ADDR_W:0]   nmatch;
   logic [BX_W-1:0]   bx_out;
   logic              done;
   logic              overflow;
`ifdef MATCH_REC_STATS_EN
   logic [15:0]       drop_cnt;

   modport master (
      output start, valid, match, rd_add,
      input  matchout, nmatch, bx_out, done, overflow, drop_cnt
   );
   modport slave (
      input  start, valid, match, rd_add,
      output matchout, nmatch, bx_out, done, overflow, drop_cnt
   );
`else
   modport master (
      output start, valid, match, rd_add,
      input  matchout, nmatch, bx_out, done, overflow
   );
   modport slave (
      input  start, valid, match, rd_add,
      output matchout, nmatch, bx_out, done, overflow
   );
`endif

endinterface

// File: rtl/match_rec_dpram.sv
// Ping-pong page store: 2*DEPTH words, one write and one read port.
// Read data is registered (one cycle latency); array is never reset.
module match_rec_dpram
   import match_rec_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [ADDR_W:0] i_wr_addr,
   input  match_t        i_wr_data,
   input  logic [ADDR_W:0] i_rd_addr,
   output match_t        o_rd_data
);

   match_t r_mem [2*DEPTH];
   match_t r_q;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_q <= '0;
      else          r_q <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_q;

endmodule

// File: rtl/match_rec_collector.sv
// Collects tagged matches into one ping-pong page per BX and publishes
// the closed page. Define MATCH_REC_STATS_EN for the drop_cnt counter.
module match_rec_collector
   import match_rec_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic                 proc_clk,
   input  logic                 reset,
   match_rec_collector_if.slave bus
);

   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

   state_t          r_state;
   state_t          w_state_nx;
   logic            r_wr_page;
   logic [ADDR_W:0] r_wr_cnt;
   logic [BX_W-1:0] r_bx;
   logic            r_ovf;
   logic [ADDR_W:0] r_nmatch;
   logic [BX_W-1:0] r_bx_out;
   logic            r_ovf_out;
   logic            r_done;

   logic            w_tagged;
   logic            w_acc;
   logic            w_open;
   logic            w_close;
   logic            w_full;
   logic            w_we;
   logic [ADDR_W:0] w_wr_addr;
   logic [ADDR_W:0] w_rd_addr;
   match_t          w_rd_data;

   assign w_tagged = bus.valid && (bus.match[TAG_HI:TAG_LO] != '0);
   assign w_acc    = w_tagged && (r_state == COLLECT);
   assign w_open   = (r_state == IDLE) && bus.start;
   assign w_close  = (r_state == COLLECT) && bus.start;
   assign w_full   = (r_wr_cnt == FULL);

   // A match landing on the close cycle opens the new page at slot 0.
   assign w_we      = w_acc && (w_close || !w_full);
   assign w_wr_addr = w_close ? {~r_wr_page, {ADDR_W{1'b0}}}
                              : {r_wr_page, r_wr_cnt[ADDR_W-1:0]};
   assign w_rd_addr = {~r_wr_page, bus.rd_add};

   always_ff @(posedge proc_clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         IDLE:    if (bus.start) w_state_nx = COLLECT;
         COLLECT: w_state_nx = COLLECT;
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge proc_clk or negedge reset) begin
      if (!reset) begin
         r_wr_page <= 1'b0;
         r_wr_cnt  <= '0;
         r_bx      <= '0;
         r_ovf     <= 1'b0;
         r_nmatch  <= '0;
         r_bx_out  <= '0;
         r_ovf_out <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_open) begin
            r_wr_page <= 1'b0;
            r_wr_cnt  <= '0;
            r_bx      <= '0;
            r_ovf     <= 1'b0;
         end else if (w_close) begin
            r_nmatch  <= r_wr_cnt;
            r_bx_out  <= r_bx;
            r_ovf_out <= r_ovf;
            r_done    <= 1'b1;
            r_wr_page <= ~r_wr_page;
            r_bx      <= r_bx + 3'd1;
            r_wr_cnt  <= w_acc ? (ADDR_W+1)'(1) : '0;
            r_ovf     <= 1'b0;
         end else if (w_acc) begin
            if (w_full) r_ovf <= 1'b1;
            else        r_wr_cnt <= r_wr_cnt + 1'b1;
         end
      end
   end

   match_rec_dpram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk     (proc_clk),
      .i_rst_n   (reset),
      .i_we      (w_we),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (bus.match),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data)
   );

   assign bus.matchout = w_rd_data;
   assign bus.nmatch   = r_nmatch;
   assign bus.bx_out   = r_bx_out;
   assign bus.overflow = r_ovf_out;
   assign bus.done     = r_done;

`ifdef MATCH_REC_STATS_EN
   logic [15:0] r_drop_cnt;
   logic        w_drop;

   assign w_drop = (w_tagged && (r_state == IDLE))
                || (w_acc && !w_close && w_full);

   always_ff @(posedge proc_clk or negedge reset) begin
      if (!reset) r_drop_cnt <= '0;
      else if (w_drop && (r_drop_cnt != 16'hFFFF))
         r_drop_cnt <= r_drop_cnt + 16'd1;
   end

   assign bus.drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_match_rec_collector.sv
// Directed bench for match_rec_collector (default and MATCH_REC_STATS_EN).
module tb_match_rec_collector;
   import match_rec_pkg::*;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_done;

   match_rec_collector_if #(.ADDR_W(ADDR_W)) bus ();

   match_rec_collector #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .proc_clk (clk),
      .reset    (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input match_t m);
      bus.valid = 1'b1;
      bus.match = m;
      cyc();
      bus.valid = 1'b0;
      bus.match = '0;
   endtask

   task automatic close(input string tag, input int n, input int bx,
                        input int ov);
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      chk({tag, "_done"}, 64'(bus.done), 64'd1);
      chk({tag, "_nmatch"}, 64'(bus.nmatch), 64'(n));
      chk({tag, "_bx"}, 64'(bus.bx_out), 64'(bx));
      chk({tag, "_ovf"}, 64'(bus.overflow), 64'(ov));
      cyc();
      chk({tag, "_done_lo"}, 64'(bus.done), 64'd0);
   endtask

   task automatic rd(input string tag, input int a, input match_t exp);
      bus.rd_add = ADDR_W'(a);
      cyc();
      chk(tag, 64'(bus.matchout), 64'(exp));
   endtask

   task automatic reset_now(input string tag);
      rst_n = 1'b0;
      #2;
      chk({tag, "_nmatch"}, 64'(bus.nmatch), 64'd0);
      chk({tag, "_bx"}, 64'(bus.bx_out), 64'd0);
      chk({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
      chk({tag, "_done"}, 64'(bus.done), 64'd0);
      chk({tag, "_rdata"}, 64'(bus.matchout), 64'd0);
`ifdef MATCH_REC_STATS_EN
      chk({tag, "_drops"}, 64'(bus.drop_cnt), 64'd0);
`endif
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.valid  = 1'b0;
      bus.match  = '0;
      bus.rd_add = '0;
      #3;
      reset_now("rst0");

      // first start only opens collection
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      chk("open_done", 64'(bus.done), 64'd0);
      chk("open_nmatch", 64'(bus.nmatch), 64'd0);

      for (int i = 0; i < 5; i++) push({4'h1, 40'(i)});
      close("t1", 5, 0, 0);
      for (int i = 0; i < 5; i++) rd("t1_rd", i, {4'h1, 40'(i)});

      for (int i = 0; i < 70; i++) push({4'h2, 40'(i)});
      close("t2", 64, 1, 1);
      rd("t2_rd0", 0, {4'h2, 40'd0});
      rd("t2_rd63", 63, {4'h2, 40'd63});
`ifdef MATCH_REC_STATS_EN
      chk("t2_drops", 64'(bus.drop_cnt), 64'd6);
`endif
      for (int i = 0; i < 3; i++) push({4'h5, 40'(i)});
      close("t2b", 3, 2, 0);

      for (int i = 0; i < 4; i++) begin
         push({4'h0, 40'hBAD0 + 40'(i)});
         push({4'h3, 40'h100 + 40'(i)});
      end
      close("t3", 4, 3, 0);
      for (int i = 0; i < 4; i++) rd("t3_rd", i, {4'h3, 40'h100 + 40'(i)});

      push({4'h4, 40'hA0});
      push({4'h4, 40'hA1});
      bus.start = 1'b1;
      bus.valid = 1'b1;
      bus.match = {4'h6, 40'hC0FFEE};
      cyc();
      bus.start = 1'b0;
      bus.valid = 1'b0;
      bus.match = '0;
      chk("t4_done", 64'(bus.done), 64'd1);
      chk("t4_nmatch", 64'(bus.nmatch), 64'd2);
      chk("t4_bx", 64'(bus.bx_out), 64'd4);
      push({4'h7, 40'hD1});
      close("t4b", 2, 5, 0);
      rd("t4_rdX", 0, {4'h6, 40'hC0FFEE});
      rd("t4_rdY", 1, {4'h7, 40'hD1});

      reset_now("rst1");
      push({4'h9, 40'h55});
`ifdef MATCH_REC_STATS_EN
      chk("t5_idle_drop", 64'(bus.drop_cnt), 64'd1);
`endif
      n_done = 0;
      for (int i = 0; i < 9; i++) begin
         bus.start = 1'b1;
         cyc();
         bus.start = 1'b0;
         n_done += int'(bus.done);
         if (i > 0) begin
            chk("t5_bx", 64'(bus.bx_out), 64'(i - 1));
            chk("t5_nmatch", 64'(bus.nmatch), 64'd0);
         end
         cyc();
      end
      chk("t5_ndone", 64'(n_done), 64'd8);
      close("t5_wrap", 0, 0, 0);

      for (int i = 0; i < 10; i++) push({4'h8, 40'(i)});
      reset_now("rst2");
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      chk("t6_open_done", 64'(bus.done), 64'd0);
      push({4'hA, 40'h1});
      push({4'hA, 40'h2});
      close("t6", 2, 0, 0);
      rd("t6_rd0", 0, {4'hA, 40'h1});
      rd("t6_rd1", 1, {4'hA, 40'h2});

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
